regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//  General-purpose register file terminating the MEM/WB writeback interface.
//  Accepts one write per cycle from the WB stage (wb_waddr/wb_reg_we/wb_data).
//  Serves two combinational read ports to the ID stage, with same-cycle WB->ID bypass.
//  Register 0 is hardwired to zero; a written-since-reset bitmap is kept for debug.
// PARAMETERS
//  DATA_W    32  register width (matches RegBus)
//  ADDR_W    5   register index width (matches RegAddrBus)
//  NUM_REGS  32  register count; must equal 2**ADDR_W
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       asynchronous reset, active-low (0 = reset)
//  we         in   1       write enable, driven by wb_reg_we
//  waddr      in   ADDR_W  write index, driven by wb_waddr
//  wdata      in   DATA_W  write data, driven by wb_data
//  re1        in   1       read port 1 enable
//  raddr1     in   ADDR_W  read port 1 index
//  rdata1     out  DATA_W  read port 1 data (combinational)
//  re2        in   1       read port 2 enable
//  raddr2     in   ADDR_W  read port 2 index
//  rdata2     out  DATA_W  read port 2 data (combinational)
//  written    out  NUM_REGS  bit i = reg i written since reset (registered)
// BEHAVIOUR
//  Reset (rst=0, async, no clock needed): all regs[0..NUM_REGS-1] <= 0; written <= 0.
//   While rst=0: rdata1 = rdata2 = 0 regardless of re/raddr; writes ignored.
//   Release of rst takes effect at the next rising edge; no write occurs on that edge
//   unless we=1 with rst already high before the edge.
//  Write: on posedge clk with rst=1, we=1, waddr!=0: regs[waddr] <= wdata,
//   written[waddr] <= 1. waddr==0 with we=1: no state change; written[0] stays 0.
//   we=0: no state change. One write per cycle; write latency 1 edge.
//  Read port k (k=1,2), combinational, priority order:
//   1. rst=0                                   -> 0
//   2. rek=0                                   -> 0
//   3. raddrk==0                               -> 0
//   4. we=1 and waddr==raddrk (bypass)         -> wdata (same cycle)
//   5. otherwise                               -> regs[raddrk]
//  Both ports may read the same index concurrently; both bypass independently.
//  Bypass makes a WB write visible to ID in the same cycle (no 3-cycle RAW hazard).
//  written is a pure register output; it is never cleared except by reset.
//  No X propagation: all outputs defined for every input combination after reset.
// TESTING
//  1. Pulse rst=0 mid-cycle after prior writes -> all reads 0, written=0 immediately.
//  2. we=1 waddr=5 wdata=32'h1234_5678; next cycle re1=1 raddr1=5 -> rdata1=32'h1234_5678,
//     written[5]=1.
//  3. Same cycle: we=1 waddr=7 wdata=32'hDEAD_BEEF, re1=re2=1 raddr1=raddr2=7 -> both ports
//     32'hDEAD_BEEF before the edge (bypass); regs[7] holds it after the edge.
//  4. we=1 waddr=0 wdata=32'hFFFF_FFFF; re1=1 raddr1=0 same and next cycle -> rdata1=0,
//     written[0]=0.
//  5. regs[3]=32'hA5A5_A5A5, re2=0 raddr2=3 -> rdata2=0; re2=1 -> 32'hA5A5_A5A5.
//  6. Write all 31 nonzero indices with value=index*32'h0101_0101, read back on both
//     ports -> exact values, written=32'hFFFF_FFFE.

Source files
------------

// File: rtl/regfile_if.sv
// Writeback/decode bus for the general-purpose register file.
// The pipeline side uses the master modport; the register file uses the slave modport.
interface regfile_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
);
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                re1;
    logic [ADDR_W-1:0]   raddr1;
    logic [DATA_W-1:0]   rdata1;
    logic                re2;
    logic [ADDR_W-1:0]   raddr2;
    logic [DATA_W-1:0]   rdata2;
    logic [NUM_REGS-1:0] written;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, written
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, written
    );
endinterface

// File: rtl/regfile.sv
// General-purpose register file with one WB write port and two ID read ports.
// Register 0 reads as zero; reads bypass the same-cycle WB write.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic       clk,
    input  logic       rst,
    regfile_if.slave   bus
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_written;
    logic [DATA_W-1:0]   w_rdata1;
    logic [DATA_W-1:0]   w_rdata2;

    // Priority: reset, port disabled, zero register, WB bypass, stored value.
    function automatic logic [DATA_W-1:0] f_read (
        input logic              i_rst_n,
        input logic              i_re,
        input logic [ADDR_W-1:0] i_raddr,
        input logic              i_we,
        input logic [ADDR_W-1:0] i_waddr,
        input logic [DATA_W-1:0] i_wdata,
        input logic [DATA_W-1:0] i_stored
    );
        logic [DATA_W-1:0] w_val;
        if (!i_rst_n) begin
            w_val = {DATA_W{1'b0}};
        end else if (!i_re) begin
            w_val = {DATA_W{1'b0}};
        end else if (i_raddr == {ADDR_W{1'b0}}) begin
            w_val = {DATA_W{1'b0}};
        end else if (i_we && (i_waddr == i_raddr)) begin
            w_val = i_wdata;
        end else begin
            w_val = i_stored;
        end
        return w_val;
    endfunction

    // Register array and written-since-reset bitmap; index 0 is never updated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
            r_written <= {NUM_REGS{1'b0}};
        end else if (bus.we && (bus.waddr != {ADDR_W{1'b0}})) begin
            r_regs[bus.waddr]    <= bus.wdata;
            r_written[bus.waddr] <= 1'b1;
        end else begin
            r_written <= r_written;
        end
    end

    // Combinational read ports with independent bypass.
    always_comb begin
        w_rdata1 = {DATA_W{1'b0}};
        w_rdata2 = {DATA_W{1'b0}};
        w_rdata1 = f_read(rst, bus.re1, bus.raddr1, bus.we, bus.waddr, bus.wdata,
                          r_regs[bus.raddr1]);
        w_rdata2 = f_read(rst, bus.re2, bus.raddr2, bus.we, bus.waddr, bus.wdata,
                          r_regs[bus.raddr2]);
    end

    assign bus.rdata1  = w_rdata1;
    assign bus.rdata2  = w_rdata2;
    assign bus.written = r_written;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, randomized traffic against
// an array-based model, and hand-written reset and fill sequences.
module tb_regfile;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) bus ();

    regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_regs [32];
    logic [31:0] m_written;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra,
                                             input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (!rst || !re || ra == 5'd0) return 32'd0;
        if (we && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_written = 32'd0;
    endtask

    // One bus cycle: drive after negedge, check reads before posedge, check bitmap after.
    task automatic cycle(input string tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic re1, input logic [4:0] ra1,
                         input logic re2, input logic [4:0] ra2,
                         input logic [31:0] exp1, input logic [31:0] exp2);
        @(negedge clk);
        bus.we = we; bus.waddr = wa; bus.wdata = wd;
        bus.re1 = re1; bus.raddr1 = ra1; bus.re2 = re2; bus.raddr2 = ra2;
        #1;
        check({tag, "_rdata1"}, bus.rdata1, exp1);
        check({tag, "_rdata2"}, bus.rdata2, exp2);
        @(posedge clk);
        if (rst && we && wa != 5'd0) begin
            m_regs[wa]    = wd;
            m_written[wa] = 1'b1;
        end
        #1;
        check({tag, "_written"}, bus.written, m_written);
    endtask

    task automatic rand_cycle(input string tag);
        logic        we, re1, re2;
        logic [4:0]  wa, ra1, ra2;
        logic [31:0] wd;
        we  = 1'($urandom_range(0, 1));
        wa  = 5'($urandom_range(0, 31));
        wd  = 32'($urandom);
        re1 = ($urandom_range(0, 7) != 0);
        re2 = ($urandom_range(0, 7) != 0);
        ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
        ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
        cycle(tag, we, wa, wd, re1, ra1, re2, ra2,
              exp_read(re1, ra1, we, wa, wd), exp_read(re2, ra2, we, wa, wd));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_clear();
        rst = 1'b0;
        bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd4; bus.re2 = 1'b1; bus.raddr2 = 5'd9;

        // Reset state
        #2;
        check("reset_rdata1", bus.rdata1, 32'd0);
        check("reset_rdata2", bus.rdata2, 32'd0);
        check("reset_written", bus.written, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        vecs[0] = '{1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 1'b1, 5'd3, 32'h1234_5678, 32'd0};
        vecs[1] = '{1'b0, 5'd0, 32'd0,         1'b1, 5'd5, 1'b0, 5'd5, 32'h1234_5678, 32'd0};
        vecs[2] = '{1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 5'd7, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 5'd7, 32'd0,         1'b1, 5'd7, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 32'd0,         32'd0};
        vecs[5] = '{1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd5, 32'd0,         32'h1234_5678};
        vecs[6] = '{1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd3, 1'b0, 5'd3, 32'd0,         32'd0};
        vecs[7] = '{1'b0, 5'd0, 32'd0,         1'b1, 5'd3, 1'b0, 5'd3, 32'hA5A5_A5A5, 32'd0};
        vecs[8] = '{1'b0, 5'd0, 32'd0,         1'b1, 5'd31, 1'b1, 5'd3, 32'd0,        32'hA5A5_A5A5};
        vecs[9] = '{1'b1, 5'd31, 32'h0000_0001, 1'b1, 5'd31, 1'b1, 5'd30, 32'h0000_0001, 32'd0};

        for (int v = 0; v < 10; v++) begin
            cycle($sformatf("vec%0d", v), vecs[v].we, vecs[v].wa, vecs[v].wd,
                  vecs[v].re1, vecs[v].ra1, vecs[v].re2, vecs[v].ra2,
                  vecs[v].exp1, vecs[v].exp2);
        end
        check("vec_written_bits", bus.written, 32'h8000_00A8);

        for (int n = 0; n < 300; n++) rand_cycle($sformatf("rand%0d", n));

        // Mid-cycle reset pulse after prior writes, with a bypass-qualifying write pending
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hCAFE_F00D;
        bus.re1 = 1'b1; bus.raddr1 = 5'd5; bus.re2 = 1'b1; bus.raddr2 = 5'd7;
        #2;
        rst = 1'b0;
        #1;
        check("rstpulse_rdata1", bus.rdata1, 32'd0);
        check("rstpulse_rdata2", bus.rdata2, 32'd0);
        check("rstpulse_written", bus.written, 32'd0);
        @(posedge clk);
        #1;
        check("rsthold_written", bus.written, 32'd0);
        check("rsthold_rdata1", bus.rdata1, 32'd0);
        @(negedge clk);
        bus.we = 1'b0;
        rst = 1'b1;
        model_clear();
        cycle("postrst_a", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd7, 32'd0, 32'd0);

        // Fill every nonzero register, then read back on both ports
        for (int i = 1; i < 32; i++) begin
            cycle($sformatf("fill%0d", i), 1'b1, 5'(i), 32'(i) * 32'h0101_0101,
                  1'b0, 5'(i), 1'b0, 5'(i), 32'd0, 32'd0);
        end
        for (int i = 1; i < 32; i++) begin
            cycle($sformatf("readback%0d", i), 1'b0, 5'd0, 32'd0,
                  1'b1, 5'(i), 1'b1, 5'(32 - i),
                  32'(i) * 32'h0101_0101, 32'(32 - i) * 32'h0101_0101);
        end
        check("fill_written", bus.written, 32'hFFFF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
